// File: rtl/sram_read_arbiter_pkg.sv
// Shared constants for the SRAM read arbiter and the datapath around the shared SRAM.
// Holds the arbiter state encoding and default bus widths.
package sram_read_arbiter_pkg;

    localparam int ARB_ADDR_W      = 12;
    localparam int ARB_DATA_W      = 16;
    localparam int ARB_MAX_BURST   = 16;

    localparam int SRAM_DEPTH      = 1 << ARB_ADDR_W;
    localparam int SRAM_RD_LATENCY = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    function automatic arb_state_e own_state(input logic who);
        return who ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/sram_read_arbiter_if.sv
// Requester-side bundle of the SRAM read arbiter (two requesters).
// Master is the requester side, slave is the arbiter side.
interface sram_read_arbiter_if
    import sram_read_arbiter_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W
);
    logic              rq0_req;
    logic              rq1_req;
    logic [ADDR_W-1:0] rq0_addr;
    logic [ADDR_W-1:0] rq1_addr;
    logic              rq0_lock;
    logic              rq1_lock;
    logic              rq0_gnt;
    logic              rq1_gnt;
    logic              rq0_rvalid;
    logic              rq1_rvalid;
    logic [DATA_W-1:0] rq0_rdata;
    logic [DATA_W-1:0] rq1_rdata;

    modport master (
        output rq0_req, rq1_req, rq0_addr, rq1_addr, rq0_lock, rq1_lock,
        input  rq0_gnt, rq1_gnt, rq0_rvalid, rq1_rvalid, rq0_rdata, rq1_rdata
    );

    modport slave (
        input  rq0_req, rq1_req, rq0_addr, rq1_addr, rq0_lock, rq1_lock,
        output rq0_gnt, rq1_gnt, rq0_rvalid, rq1_rvalid, rq0_rdata, rq1_rdata
    );

endinterface

// File: rtl/sram_read_arbiter_rr_pick2.sv
// Two-way round-robin pick: one-hot grant from two requests and a pointer; purely combinational.
// A lone request always wins; on a tie the pointer chooses.
module rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       rr_ptr_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = rr_ptr_i ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/sram_read_arbiter.sv
// Two-requester arbiter for one SRAM read port; grant is combinational, rvalid/rdata one cycle later.
// Requesters hold req/addr until gnt; locked bursts are capped at MAX_BURST when the other side waits.
module sram_read_arbiter
    import sram_read_arbiter_pkg::*;
#(
    parameter int ADDR_W    = ARB_ADDR_W,
    parameter int DATA_W    = ARB_DATA_W,
    parameter int MAX_BURST = ARB_MAX_BURST
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              rq0_req,
    input  logic              rq1_req,
    input  logic [ADDR_W-1:0] rq0_addr,
    input  logic [ADDR_W-1:0] rq1_addr,
    input  logic              rq0_lock,
    input  logic              rq1_lock,
    output logic              rq0_gnt,
    output logic              rq1_gnt,
    output logic              rq0_rvalid,
    output logic              rq1_rvalid,
    output logic [DATA_W-1:0] rq0_rdata,
    output logic [DATA_W-1:0] rq1_rdata,
    output logic [ADDR_W-1:0] sram_read_address,
    input  logic [DATA_W-1:0] sram_read_data
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    arb_state_e        state_q, state_d;
    logic              rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        rvalid_q, rvalid_d;

    logic [1:0] req_vec;
    logic [1:0] lock_vec;
    logic [1:0] pick_gnt;
    logic [1:0] gnt;
    logic       who;

    assign req_vec  = {rq1_req, rq0_req};
    assign lock_vec = {rq1_lock, rq0_lock};

    rr_pick2 u_pick (
        .req_i    (req_vec),
        .rr_ptr_i (rr_ptr_q),
        .gnt_o    (pick_gnt)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        gnt         = 2'b00;
        who         = 1'b0;
        case (state_q)
            IDLE: begin
                gnt = pick_gnt;
                who = pick_gnt[1];
                if (pick_gnt != 2'b00) begin
                    rr_ptr_d = ~who;
                    if (lock_vec[who]) begin
                        state_d     = own_state(who);
                        burst_cnt_d = CNT_W'(1);
                    end
                end
            end
            OWN0, OWN1: begin
                who = (state_q == OWN1);
                if (req_vec[who]) begin
                    gnt[who]    = 1'b1;
                    burst_cnt_d = (burst_cnt_q == CNT_MAX) ? burst_cnt_q
                                                           : burst_cnt_q + CNT_W'(1);
                    // Starvation bound: a waiting peer forces release once the cap is hit.
                    if (!lock_vec[who] || (burst_cnt_d == CNT_MAX && req_vec[~who])) begin
                        state_d     = IDLE;
                        rr_ptr_d    = ~who;
                        burst_cnt_d = '0;
                    end
                end else begin
                    state_d     = IDLE;
                    rr_ptr_d    = ~who;
                    burst_cnt_d = '0;
                end
            end
            default: begin
                state_d     = IDLE;
                burst_cnt_d = '0;
            end
        endcase

        // Reset must clear the grant at once, not just at the next edge.
        gnt = gnt & {2{reset_b}};

        if (gnt[1])      sram_read_address = rq1_addr;
        else if (gnt[0]) sram_read_address = rq0_addr;
        else             sram_read_address = addr_q;

        addr_d   = sram_read_address;
        rvalid_d = gnt;
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q     <= IDLE;
            rr_ptr_q    <= 1'b0;
            burst_cnt_q <= '0;
            addr_q      <= '0;
            rvalid_q    <= 2'b00;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            addr_q      <= addr_d;
            rvalid_q    <= rvalid_d;
        end
    end

    assign rq0_gnt    = gnt[0];
    assign rq1_gnt    = gnt[1];
    assign rq0_rvalid = rvalid_q[0];
    assign rq1_rvalid = rvalid_q[1];
    assign rq0_rdata  = rvalid_q[0] ? sram_read_data : '0;
    assign rq1_rdata  = rvalid_q[1] ? sram_read_data : '0;

endmodule

// File: tb/tb_sram_read_arbiter.sv
// Directed bench for sram_read_arbiter: table-driven grants checked inline, read returns
// checked by a negedge monitor against a queue of expected (requester, word) pairs.
module tb_sram_read_arbiter;
    import sram_read_arbiter_pkg::*;

    localparam int AW = 12;
    localparam int DW = 16;

    logic clk     = 1'b0;
    logic reset_b = 1'b0;
    always #5 clk = ~clk;

    sram_read_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) arb_if ();

    logic [AW-1:0] sram_read_address;
    logic [DW-1:0] sram_read_data = '0;

    sram_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(16)) dut (
        .clk               (clk),
        .reset_b           (reset_b),
        .rq0_req           (arb_if.rq0_req),
        .rq1_req           (arb_if.rq1_req),
        .rq0_addr          (arb_if.rq0_addr),
        .rq1_addr          (arb_if.rq1_addr),
        .rq0_lock          (arb_if.rq0_lock),
        .rq1_lock          (arb_if.rq1_lock),
        .rq0_gnt           (arb_if.rq0_gnt),
        .rq1_gnt           (arb_if.rq1_gnt),
        .rq0_rvalid        (arb_if.rq0_rvalid),
        .rq1_rvalid        (arb_if.rq1_rvalid),
        .rq0_rdata         (arb_if.rq0_rdata),
        .rq1_rdata         (arb_if.rq1_rdata),
        .sram_read_address (sram_read_address),
        .sram_read_data    (sram_read_data)
    );

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {4'hA, a};
    endfunction

    // SRAM model: word appears one cycle after its address.
    always @(posedge clk) sram_read_data <= mem_word(sram_read_address);

    typedef struct {
        logic          who;
        logic [DW-1:0] dat;
    } rd_exp_t;

    rd_exp_t       exp_q[$];
    int            n_chk = 0;
    int            n_fail = 0;
    logic [AW-1:0] hold_addr = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        rd_exp_t e;
        chk("rvalid_pair", 32'(arb_if.rq0_rvalid & arb_if.rq1_rvalid), 32'd0);
        if (arb_if.rq0_rvalid || arb_if.rq1_rvalid) begin
            if (exp_q.size() == 0) begin
                chk("rvalid_unexpected", 32'({arb_if.rq1_rvalid, arb_if.rq0_rvalid}), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rvalid_who", 32'({arb_if.rq1_rvalid, arb_if.rq0_rvalid}),
                    e.who ? 32'd2 : 32'd1);
                chk("rdata", 32'(e.who ? arb_if.rq1_rdata : arb_if.rq0_rdata), 32'(e.dat));
            end
        end
        if (!arb_if.rq0_rvalid) chk("rq0_rdata_idle", 32'(arb_if.rq0_rdata), 32'd0);
        if (!arb_if.rq1_rvalid) chk("rq1_rdata_idle", 32'(arb_if.rq1_rdata), 32'd0);
    end

    task automatic drive(input logic r0, input logic r1, input logic [AW-1:0] a0,
                         input logic [AW-1:0] a1, input logic l0, input logic l1);
        arb_if.rq0_req  = r0;
        arb_if.rq1_req  = r1;
        arb_if.rq0_addr = a0;
        arb_if.rq1_addr = a1;
        arb_if.rq0_lock = l0;
        arb_if.rq1_lock = l1;
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
    task automatic step(input logic r0, input logic r1, input logic [AW-1:0] a0,
                        input logic [AW-1:0] a1, input logic l0, input logic l1,
                        input logic [1:0] eg, input string tag);
        rd_exp_t e;
        drive(r0, r1, a0, a1, l0, l1);
        #2;
        chk({tag, "_gnt"}, 32'({arb_if.rq1_gnt, arb_if.rq0_gnt}), 32'(eg));
        if (eg == 2'b01) begin
            hold_addr = a0;
            e.who = 1'b0; e.dat = mem_word(a0); exp_q.push_back(e);
        end else if (eg == 2'b10) begin
            hold_addr = a1;
            e.who = 1'b1; e.dat = mem_word(a1); exp_q.push_back(e);
        end
        chk({tag, "_addr"}, 32'(sram_read_address), 32'(hold_addr));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input string tag);
        for (int k = 0; k < n; k++) step(0, 0, '0, '0, 0, 0, 2'b00, tag);
    endtask

    // Reset lands mid-cycle with requests still applied; any pending read is discarded.
    task automatic apply_reset(input string tag);
        #1;
        reset_b = 1'b0;
        exp_q.delete();
        hold_addr = '0;
        #1;
        chk({tag, "_gnt"},    32'({arb_if.rq1_gnt, arb_if.rq0_gnt}), 32'd0);
        chk({tag, "_rvalid"}, 32'({arb_if.rq1_rvalid, arb_if.rq0_rvalid}), 32'd0);
        chk({tag, "_addr"},   32'(sram_read_address), 32'd0);
        drive(0, 0, '0, '0, 0, 0);
        @(posedge clk);
        #1;
        chk({tag, "_rvalid_hold"}, 32'({arb_if.rq1_rvalid, arb_if.rq0_rvalid}), 32'd0);
        chk({tag, "_addr_hold"},   32'(sram_read_address), 32'd0);
        reset_b = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        drive(0, 0, '0, '0, 0, 0);
        @(posedge clk);
        #1;
        apply_reset("por");

        // Single requester, first edge after reset
        step(1, 0, 12'h010, 12'h000, 0, 0, 2'b01, "single0");
        idle(1, "single0_idle");

        // Both requesting without lock alternate starting at 0
        apply_reset("rst_rr");
        for (int i = 0; i < 4; i++)
            step(1, 1, 12'h100, 12'h200, 0, 0, (i % 2 == 0) ? 2'b01 : 2'b10, "alt");

        // rq1 owns three cycles, rq0 follows right after the lock drops
        step(0, 1, 12'h060, 12'h050, 0, 1, 2'b10, "lock1_a");
        step(1, 1, 12'h060, 12'h051, 0, 1, 2'b10, "lock1_b");
        step(1, 1, 12'h060, 12'h052, 0, 0, 2'b10, "lock1_c");
        step(1, 0, 12'h060, 12'h000, 0, 0, 2'b01, "lock1_after");

        // Held address with no traffic
        step(1, 0, 12'h3FF, 12'h000, 0, 0, 2'b01, "hold_grant");
        idle(10, "hold_idle");

        // Burst cap: rq0 locks for 20, rq1 waits and gets cycle 17
        apply_reset("rst_cap");
        for (int i = 0; i < 20; i++)
            step(1, (i <= 16), AW'(12'h400 + i), 12'h7AA, 1, 0,
                 (i == 16) ? 2'b10 : 2'b01, "cap");
        idle(1, "cap_release");

        // Saturation: rq0 alone keeps ownership past the cap, then yields once rq1 arrives
        for (int i = 0; i < 22; i++)
            step((i <= 20), (i >= 20), AW'(12'h500 + i), 12'h6BB, 1, 0,
                 (i <= 20) ? 2'b01 : 2'b10, "sat");

        // Reset during an rq1 burst with burst_cnt at 5
        for (int i = 0; i < 5; i++)
            step(0, 1, 12'h000, AW'(12'h0C0 + i), 0, 1, 2'b10, "burst1");
        apply_reset("mid_burst");
        step(1, 1, 12'h111, 12'h222, 0, 0, 2'b01, "post_rst_a");
        step(1, 1, 12'h111, 12'h222, 0, 0, 2'b10, "post_rst_b");
        idle(3, "drain");

        chk("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_read_arbiter.md
SRAM_READ_ARBITER -- requirements
Module: sram_read_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, SRAM address width.
REQ-002 SHALL have parameter DATA_W, default 16, SRAM data width.
REQ-003 SHALL have parameter MAX_BURST, default 16, maximum consecutive locked grants.
REQ-004 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port reset_b  input  1  asynchronous active-low reset.
REQ-006 SHALL have ports rq0_req, rq1_req  input  1  read request per requester (0 = conv datapath, 1 = loader).
REQ-007 SHALL have ports rq0_addr, rq1_addr  input  ADDR_W  requested read address.
REQ-008 SHALL have ports rq0_lock, rq1_lock  input  1  request to keep ownership for the next cycle (burst).
REQ-009 SHALL have ports rq0_gnt, rq1_gnt  output  1  request accepted this cycle.
REQ-010 SHALL have ports rq0_rvalid, rq1_rvalid  output  1  read data valid for that requester.
REQ-011 SHALL have ports rq0_rdata, rq1_rdata  output  DATA_W  read data.
REQ-012 SHALL have port sram_read_address  output  ADDR_W  to shared SRAM read port.
REQ-013 SHALL have port sram_read_data  input  DATA_W  from SRAM, valid one cycle after address.

Function
REQ-014 SHALL grant at most one requester per cycle; gnt is combinational from req and current state.
REQ-015 SHALL drive sram_read_address with the granted requester's address in the grant cycle; with no grant, SHALL hold last driven address (registered).
REQ-016 SHALL assert rqN_rvalid exactly one cycle after rqN_gnt, for one cycle per grant.
REQ-017 SHALL drive rqN_rdata = sram_read_data when rqN_rvalid, else 0.
REQ-018 SHALL use FSM states IDLE, OWN0, OWN1.
REQ-019 IDLE: if one requester asserts req, SHALL grant it; if both, SHALL grant the requester indicated by 1-bit round-robin pointer rr_ptr (reset 0).
REQ-020 After any grant in IDLE or at lock release, SHALL set rr_ptr to the non-granted requester.
REQ-021 Grant with lock=1 SHALL move to OWNn and set burst_cnt = 1; grant with lock=0 SHALL stay in IDLE.
REQ-022 OWNn: SHALL grant only requester n while req_n=1, incrementing burst_cnt; the other requester SHALL NOT be granted.
REQ-023 OWNn: req_n=0 or lock_n=0 on the granted cycle SHALL return to IDLE next cycle.
REQ-024 OWNn: when burst_cnt reaches MAX_BURST and the other requester has req=1, SHALL return to IDLE and set rr_ptr to the other requester, ignoring lock (starvation bound).
REQ-025 burst_cnt reaching MAX_BURST with the other requester idle SHALL saturate, with ownership kept.
REQ-026 Simultaneous IDLE requests SHALL produce alternating grants (0,1,0,1...) when neither locks.
REQ-027 Requester changing addr while not granted SHALL have no effect; requester SHALL hold req and addr until gnt.

Reset
REQ-028 reset_b=0 SHALL immediately force state IDLE, rr_ptr 0, burst_cnt 0, rvalid both 0, held address 0, independent of clk.
REQ-029 A read granted in the cycle reset asserts SHALL NOT produce rvalid after reset release.
REQ-030 First grant SHALL be possible in the first clk edge after reset_b deasserts.

Structure
REQ-031 Arbiter state encoding, ADDR_W/DATA_W defaults, and MAX_BURST default SHALL reside in a shared package with the datapath's SRAM constants.
REQ-032 The round-robin pick (two reqs + rr_ptr -> one-hot grant) SHALL be a sub-module rr_pick2; all else inline.

Verification
REQ-033 rq0_req=1 addr=0x010 alone -> rq0_gnt same cycle, sram_read_address=0x010, rq0_rvalid next cycle with SRAM word.
REQ-034 Both req, no lock, 4 cycles after reset, addr0=0x100 addr1=0x200 -> grants 0,1,0,1; addresses 0x100,0x200,0x100,0x200.
REQ-035 rq1 locks 3 cycles with rq0 requesting -> rq1 granted 3 cycles, then rq0 granted on the cycle after lock drops.
REQ-036 rq0 holds lock for 20 cycles, rq1 requesting from cycle 0 -> rq0 granted 16 cycles, rq1 granted cycle 17.
REQ-037 reset_b pulsed low mid-burst (OWN1, burst_cnt=5) -> outputs clear asynchronously, no rvalid after release, rr_ptr=0.
REQ-038 No requests for 10 cycles after grant to addr 0x3FF -> sram_read_address held at 0x3FF, no rvalid.
